// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the processor-memory bus between icache and dcache,
// tracks which cache owns each outstanding load tag, and routes returning
// tagged data back to its owner. Stores get a response tag but no data return.

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif

package mem_bus_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TAG_W        = $clog2(`NUM_MEM_TAGS),
    parameter int DATA_W       = `DATA_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  BUS_COMMAND        icache_command,
    input  logic [31:0]       icache_addr,
    input  BUS_COMMAND        dcache_command,
    input  logic [31:0]       dcache_addr,
    input  logic [DATA_W-1:0] dcache_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output BUS_COMMAND        proc2mem_command,
    output logic [31:0]       proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    output logic [TAG_W-1:0]  icache_response,
    output logic [TAG_W-1:0]  dcache_response,
    output logic [TAG_W-1:0]  icache_tag,
    output logic [TAG_W-1:0]  dcache_tag,
    output logic [DATA_W-1:0] icache_data,
    output logic [DATA_W-1:0] dcache_data_o,
    output logic              tag_error
);

    // Table indexed directly by tag value; entry 0 is never allocated
    // because a zero tag means "none/rejected".
    localparam int TBL_N = 1 << TAG_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             ic_req, dc_req, ic_prio;
    logic             grant_ic, grant_dc;
    logic [CNT_W-1:0] starve_cnt;
    logic [TBL_N-1:0] tbl_valid;
    logic [TBL_N-1:0] tbl_dc;      // owner bit: 1 = dcache, 0 = icache
    logic             ret_tagged, ret_hit, alloc, clr_same, err_set;

    // Request decode and grant: dcache first unless icache has starved
    // long enough. Grants are forced off while reset is held.
    always_comb begin
        ic_req   = (icache_command == BUS_LOAD);
        dc_req   = (dcache_command == BUS_LOAD) || (dcache_command == BUS_STORE);
        ic_prio  = (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_ic = reset && ic_req && (!dc_req || ic_prio);
        grant_dc = reset && dc_req && !grant_ic;
    end

    // Bus mux and response steering for the granted requester
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        icache_response  = '0;
        dcache_response  = '0;
        if (grant_ic) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_addr;
            icache_response  = mem2proc_response;
        end else if (grant_dc) begin
            proc2mem_command = dcache_command;
            proc2mem_addr    = dcache_addr;
            proc2mem_data    = dcache_data;
            dcache_response  = mem2proc_response;
        end
    end

    // Owner-table lookups for this cycle's return, allocation and error cases
    always_comb begin
        ret_tagged = (mem2proc_tag != '0);
        ret_hit    = ret_tagged && tbl_valid[mem2proc_tag];
        alloc      = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
        // A return freeing the same tag that is being re-allocated is legal.
        clr_same   = ret_hit && (mem2proc_tag == mem2proc_response);
        err_set    = (alloc && tbl_valid[mem2proc_response] && !clr_same)
                   || (ret_tagged && !tbl_valid[mem2proc_tag]);
    end

    // Zero-cycle routing of returned data to the recorded owner
    always_comb begin
        icache_tag    = (reset && ret_hit && !tbl_dc[mem2proc_tag]) ? mem2proc_tag : '0;
        dcache_tag    = (reset && ret_hit &&  tbl_dc[mem2proc_tag]) ? mem2proc_tag : '0;
        icache_data   = mem2proc_data;
        dcache_data_o = mem2proc_data;
    end

    // Starvation counter: counts consecutive cycles icache is denied
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!ic_req || grant_ic)
            starve_cnt <= '0;
        else if (!ic_prio)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Owner table: clear on return, then set on accepted load (set wins)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tbl_valid <= '0;
            tbl_dc    <= '0;
        end else begin
            if (ret_hit)
                tbl_valid[mem2proc_tag] <= 1'b0;
            if (alloc) begin
                tbl_valid[mem2proc_response] <= 1'b1;
                tbl_dc[mem2proc_response]    <= grant_dc;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tag_error <= 1'b0;
        else if (err_set)
            tag_error <= 1'b1;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand
// sequences for starvation/store/reset corners, and randomized traffic
// against a tag-ownership reference model.

module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;
    localparam int LIMIT  = 4;

    logic              clock, reset;
    BUS_COMMAND        icache_command, dcache_command, proc2mem_command;
    logic [31:0]       icache_addr, dcache_addr, proc2mem_addr;
    logic [DATA_W-1:0] dcache_data, mem2proc_data, proc2mem_data;
    logic [DATA_W-1:0] icache_data, dcache_data_o;
    logic [TAG_W-1:0]  mem2proc_response, mem2proc_tag;
    logic [TAG_W-1:0]  icache_response, dcache_response, icache_tag, dcache_tag;
    logic              tag_error;

    mem_bus_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr),
        .dcache_data(dcache_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .icache_response(icache_response), .dcache_response(dcache_response),
        .icache_tag(icache_tag), .dcache_tag(dcache_tag),
        .icache_data(icache_data), .dcache_data_o(dcache_data_o),
        .tag_error(tag_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model: owner per tag (0 none, 1 icache, 2 dcache),
    // consecutive icache denials, sticky error.
    int own [16];
    int denied;
    bit merr;

    typedef struct {
        BUS_COMMAND  icmd;
        logic [31:0] iaddr;
        BUS_COMMAND  dcmd;
        logic [31:0] daddr;
        logic [63:0] ddata;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] mdata;
        BUS_COMMAND  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_iresp;
        logic [3:0]  e_dresp;
        logic [3:0]  e_itag;
        logic [3:0]  e_dtag;
        logic        e_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive(BUS_COMMAND ic, logic [31:0] ia, BUS_COMMAND dc, logic [31:0] da,
                         logic [63:0] dd, logic [3:0] rs, logic [3:0] tg, logic [63:0] md);
        icache_command    = ic;
        icache_addr       = ia;
        dcache_command    = dc;
        dcache_addr       = da;
        dcache_data       = dd;
        mem2proc_response = rs;
        mem2proc_tag      = tg;
        mem2proc_data     = md;
    endtask

    // Drive on the falling edge, let combinational outputs settle.
    task automatic apply(BUS_COMMAND ic, logic [31:0] ia, BUS_COMMAND dc, logic [31:0] da,
                         logic [63:0] dd, logic [3:0] rs, logic [3:0] tg, logic [63:0] md);
        @(negedge clock);
        drive(ic, ia, dc, da, dd, rs, tg, md);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        foreach (own[i]) own[i] = 0;
        denied = 0;
        merr   = 1'b0;
    endtask

    // One model-checked cycle: compare all outputs, then advance the model.
    task automatic step(BUS_COMMAND ic, logic [31:0] ia, BUS_COMMAND dc, logic [31:0] da,
                        logic [63:0] dd, logic [3:0] rs, logic [3:0] tg, logic [63:0] md);
        bit icr, dcr;
        int win;
        BUS_COMMAND ecmd;
        apply(ic, ia, dc, da, dd, rs, tg, md);
        icr  = (ic == BUS_LOAD);
        dcr  = (dc == BUS_LOAD) || (dc == BUS_STORE);
        win  = (icr && (!dcr || denied >= LIMIT)) ? 1 : (dcr ? 2 : 0);
        ecmd = (win == 1) ? BUS_LOAD : ((win == 2) ? dc : BUS_NONE);
        chk("rnd.cmd",   proc2mem_command, ecmd);
        chk("rnd.addr",  proc2mem_addr,  (win == 1) ? ia : ((win == 2) ? da : 32'h0));
        chk("rnd.data",  proc2mem_data,  (win == 2) ? dd : 64'h0);
        chk("rnd.iresp", icache_response, (win == 1) ? rs : 4'h0);
        chk("rnd.dresp", dcache_response, (win == 2) ? rs : 4'h0);
        chk("rnd.itag",  icache_tag, (tg != 0 && own[tg] == 1) ? tg : 4'h0);
        chk("rnd.dtag",  dcache_tag, (tg != 0 && own[tg] == 2) ? tg : 4'h0);
        chk("rnd.idata", icache_data, md);
        chk("rnd.ddata", dcache_data_o, md);
        chk("rnd.err",   tag_error, merr);
        @(posedge clock);
        denied = (icr && win != 1) ? ((denied + 1 > LIMIT) ? LIMIT : denied + 1) : 0;
        if (tg != 0) begin
            if (own[tg] != 0) own[tg] = 0;
            else merr = 1'b1;
        end
        if (ecmd == BUS_LOAD && rs != 0) begin
            if (own[rs] != 0) merr = 1'b1;
            own[rs] = win;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h77, 4'h3, 4'h3, 64'h0);
        #2;
        chk("rst.cmd",   proc2mem_command, BUS_NONE);
        chk("rst.addr",  proc2mem_addr, 32'h0);
        chk("rst.dresp", dcache_response, 4'h0);
        chk("rst.dtag",  dcache_tag, 4'h0);
        chk("rst.err",   tag_error, 1'b0);

        // Directed vector table, applied in order from a fresh reset.
        vecs[0] = '{BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h11, 4'h3, 4'h0, 64'hA0,
                    BUS_LOAD, 32'h100, 64'h11, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
        vecs[1] = '{BUS_LOAD, 32'h200, BUS_STORE, 32'h40, 64'hDEADBEEF, 4'h5, 4'h0, 64'hA1,
                    BUS_STORE, 32'h40, 64'hDEADBEEF, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0};
        vecs[2] = '{BUS_LOAD, 32'h200, BUS_NONE, 32'h0, 64'h0, 4'h7, 4'h3, 64'hA2,
                    BUS_LOAD, 32'h200, 64'h0, 4'h7, 4'h0, 4'h0, 4'h3, 1'b0};
        vecs[3] = '{BUS_NONE, 32'h0, BUS_LOAD, 32'h300, 64'h33, 4'h7, 4'h7, 64'hA3,
                    BUS_LOAD, 32'h300, 64'h33, 4'h0, 4'h7, 4'h7, 4'h0, 1'b0};
        vecs[4] = '{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h7, 64'hA4,
                    BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h7, 1'b0};
        vecs[5] = '{BUS_STORE, 32'h500, BUS_NONE, 32'h0, 64'h0, 4'h2, 4'h0, 64'hA5,
                    BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 64'hA6,
                    BUS_NONE, 32'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].icmd, vecs[i].iaddr, vecs[i].dcmd, vecs[i].daddr,
                  vecs[i].ddata, vecs[i].resp, vecs[i].tag, vecs[i].mdata);
            chk($sformatf("vec%0d.cmd", i),   proc2mem_command, vecs[i].e_cmd);
            chk($sformatf("vec%0d.addr", i),  proc2mem_addr,    vecs[i].e_addr);
            chk($sformatf("vec%0d.data", i),  proc2mem_data,    vecs[i].e_data);
            chk($sformatf("vec%0d.iresp", i), icache_response,  vecs[i].e_iresp);
            chk($sformatf("vec%0d.dresp", i), dcache_response,  vecs[i].e_dresp);
            chk($sformatf("vec%0d.itag", i),  icache_tag,       vecs[i].e_itag);
            chk($sformatf("vec%0d.dtag", i),  dcache_tag,       vecs[i].e_dtag);
            chk($sformatf("vec%0d.bcast", i), icache_data,      vecs[i].mdata);
            chk($sformatf("vec%0d.err", i),   tag_error,        vecs[i].e_err);
        end

        // Starvation with memory rejecting everything: dcache wins four
        // times, icache gets the fifth grant, then dcache again.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h0, 4'h0, 4'h0, 64'h0);
            chk($sformatf("starve%0d.addr", k), proc2mem_addr, (k == 4) ? 32'h200 : 32'h100);
        end
        apply(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
        chk("starve.err", tag_error, 1'b0);

        // Store gets a tag but no table entry; its "return" is an error.
        do_reset();
        apply(BUS_NONE, 0, BUS_STORE, 32'h40, 64'hDEADBEEF, 4'h5, 4'h0, 64'h0);
        chk("store.data", proc2mem_data, 64'hDEADBEEF);
        chk("store.dresp", dcache_response, 4'h5);
        apply(BUS_NONE, 0, BUS_NONE, 0, 0, 4'h0, 4'h5, 64'h1234);
        chk("store.dtag", dcache_tag, 4'h0);
        chk("store.itag", icache_tag, 4'h0);
        chk("store.err0", tag_error, 1'b0);
        apply(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
        chk("store.err1", tag_error, 1'b1);

        // Asynchronous reset with two tags outstanding.
        do_reset();
        apply(BUS_LOAD, 32'h200, BUS_NONE, 0, 0, 4'h2, 4'h0, 64'h0);
        apply(BUS_NONE, 0, BUS_LOAD, 32'h100, 0, 4'h1, 4'h0, 64'h0);
        apply(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h9, 4'h3, 4'h2, 64'h0);
        chk("arst.pre.dresp", dcache_response, 4'h3);
        chk("arst.pre.itag", icache_tag, 4'h2);
        reset = 1'b0;
        #1;
        chk("arst.cmd",   proc2mem_command, BUS_NONE);
        chk("arst.addr",  proc2mem_addr, 32'h0);
        chk("arst.data",  proc2mem_data, 64'h0);
        chk("arst.dresp", dcache_response, 4'h0);
        chk("arst.iresp", icache_response, 4'h0);
        chk("arst.itag",  icache_tag, 4'h0);
        chk("arst.dtag",  dcache_tag, 4'h0);
        @(negedge clock);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
        reset = 1'b1;
        apply(BUS_NONE, 0, BUS_NONE, 0, 0, 4'h0, 4'h1, 64'h0);
        chk("arst.dtag_old", dcache_tag, 4'h0);
        chk("arst.err0", tag_error, 1'b0);
        apply(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
        chk("arst.err1", tag_error, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            BUS_COMMAND ic, dc;
            logic [3:0] rs, tg;
            int st;
            if (n % 150 == 0) do_reset();
            case ($urandom_range(0, 3))
                0: ic = BUS_NONE;
                3: ic = BUS_STORE;
                default: ic = BUS_LOAD;
            endcase
            case ($urandom_range(0, 3))
                0: dc = BUS_NONE;
                1: dc = BUS_STORE;
                default: dc = BUS_LOAD;
            endcase
            rs = 4'h0;
            if ($urandom_range(0, 3) != 0) begin
                st = $urandom_range(1, 15);
                rs = 4'(st);
                if ($urandom_range(0, 7) != 0)
                    for (int j = 0; j < 15; j++)
                        if (own[((st - 1 + j) % 15) + 1] == 0) begin
                            rs = 4'(((st - 1 + j) % 15) + 1);
                            break;
                        end
            end
            tg = 4'h0;
            if ($urandom_range(0, 1) == 1) begin
                st = $urandom_range(1, 15);
                for (int j = 0; j < 15; j++)
                    if (own[((st - 1 + j) % 15) + 1] != 0) begin
                        tg = 4'(((st - 1 + j) % 15) + 1);
                        break;
                    end
            end else if ($urandom_range(0, 15) == 0) begin
                tg = 4'($urandom_range(1, 15));
            end
            step(ic, $urandom, dc, $urandom, {$urandom, $urandom}, rs, tg, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
